// File: rtl/fpop_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fpop_sched_pkg
// Brief    : Shared types and constants for the FFU fpop issue scheduler.
// Revision : 1.0  initial release
// ============================================================================
package fpop_sched_pkg;

    localparam int         c_tid_w           = 2;
    // CPX request type of an FPU return; cpx_fpu_rtn is this compare, decoded upstream
    localparam logic [3:0] c_cpx_req_fpu_rtn = 4'b1000;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/fpop_rr_arb.sv
`default_nettype none
// ============================================================================
// Module   : fpop_rr_arb
// Brief    : Combinational NTHR-way round-robin picker starting at i_rr_ptr.
// Revision : 1.0  initial release
// ============================================================================
module fpop_rr_arb
    import fpop_sched_pkg::*;
#(
    parameter int NTHR = 4
) (
    input  logic [NTHR-1:0]    i_elig,
    input  logic [c_tid_w-1:0] i_rr_ptr,
    output logic [NTHR-1:0]    o_gnt,
    output logic [c_tid_w-1:0] o_tid
);

    localparam int SUM_W = c_tid_w + 1;

    logic [SUM_W-1:0]   w_sum;
    logic [c_tid_w-1:0] w_idx;
    logic               w_found;

    always_comb begin
        o_gnt   = '0;
        o_tid   = '0;
        w_found = 1'b0;
        w_sum   = '0;
        w_idx   = '0;
        for (int i = 0; i < NTHR; i++) begin
            w_sum = {1'b0, i_rr_ptr} + SUM_W'(i);
            if (w_sum >= SUM_W'(NTHR)) begin
                w_sum = w_sum - SUM_W'(NTHR);
            end
            w_idx = w_sum[c_tid_w-1:0];
            if (!w_found && i_elig[w_idx]) begin
                w_found      = 1'b1;
                o_gnt[w_idx] = 1'b1;
                o_tid        = w_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fpop_issue_sched.sv
`default_nettype none
// ============================================================================
// Module   : fpop_issue_sched
// Brief    : Round-robin fpop issue to the LSU for four threads, with in-flight
//            tracking until the CPX FPU return. Optional per-thread watchdog
//            enabled by FPOP_SCHED_TIMEOUT_EN.
// Revision : 1.0  initial release
// ============================================================================
module fpop_issue_sched
    import fpop_sched_pkg::*;
#(
    parameter int NTHR    = 4,
    parameter int PLW     = 80,
    parameter int MAX_OUT = 2,
    parameter int TO_W    = 10
) (
    input  logic                         rclk,
    input  logic                         rst,
    input  logic [NTHR-1:0]              thr_req_vld,
    input  logic [NTHR*PLW-1:0]          thr_req_pld,
    output logic [NTHR-1:0]              thr_req_gnt,
    output logic                         ffu_lsu_fpop_rq_vld,
    output logic [c_tid_w-1:0]           ffu_lsu_fpop_tid,
    output logic [PLW-1:0]               ffu_lsu_fpop_pld,
    input  logic                         lsu_ffu_ack,
    input  logic                         cpx_vld,
    input  logic                         cpx_fpu_rtn,
    input  logic [c_tid_w-1:0]           cpx_tid,
    output logic [NTHR-1:0]              thr_busy,
    output logic [NTHR-1:0]              thr_done,
    output logic [$clog2(MAX_OUT+1)-1:0] out_cnt,
`ifdef FPOP_SCHED_TIMEOUT_EN
    output logic [NTHR-1:0]              thr_timeout,
`endif
    output logic                         sched_err
);

    localparam int CNT_W = $clog2(MAX_OUT + 1);

    sched_state_t       r_state, w_state_nxt;
    logic [c_tid_w-1:0] r_rr_ptr, r_tid, w_arb_tid;
    logic [PLW-1:0]     r_pld;
    logic [NTHR-1:0]    r_busy, r_done, w_elig, w_arb_gnt, w_busy_nxt;
    logic [CNT_W-1:0]   r_out_cnt;
    logic               r_err;
    logic               w_ack, w_rtn, w_rtn_ok, w_rtn_err, w_pick;

    assign w_elig    = thr_req_vld & ~r_busy;
    assign w_ack     = (r_state == ST_REQ) && lsu_ffu_ack;
    assign w_rtn     = cpx_vld && cpx_fpu_rtn;
    // busy is sampled pre-edge, so a return racing its own ack is an error
    assign w_rtn_ok  = w_rtn && r_busy[cpx_tid];
    assign w_rtn_err = w_rtn && !r_busy[cpx_tid];

    fpop_rr_arb #(
        .NTHR (NTHR)
    ) u_arb (
        .i_elig   (w_elig),
        .i_rr_ptr (r_rr_ptr),
        .o_gnt    (w_arb_gnt),
        .o_tid    (w_arb_tid)
    );

    always_ff @(posedge rclk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pick      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|w_arb_gnt && (r_out_cnt < CNT_W'(MAX_OUT))) begin
                    w_pick      = 1'b1;
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (lsu_ffu_ack) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy_nxt = r_busy;
        if (w_rtn_ok) begin
            w_busy_nxt[cpx_tid] = 1'b0;
        end
        if (w_ack) begin
            w_busy_nxt[r_tid] = 1'b1;
        end
    end

    always_ff @(posedge rclk) begin
        if (rst) begin
            r_rr_ptr  <= '0;
            r_tid     <= '0;
            r_pld     <= '0;
            r_busy    <= '0;
            r_done    <= '0;
            r_out_cnt <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_pick) begin
                r_tid <= w_arb_tid;
                r_pld <= thr_req_pld[w_arb_tid*PLW +: PLW];
            end
            if (w_ack) begin
                r_rr_ptr <= (r_tid == c_tid_w'(NTHR - 1)) ? '0 : r_tid + c_tid_w'(1);
            end
            r_busy <= w_busy_nxt;
            r_done <= w_rtn_ok ? (NTHR'(1) << cpx_tid) : '0;
            case ({w_ack, w_rtn_ok})
                2'b10:   r_out_cnt <= r_out_cnt + CNT_W'(1);
                2'b01:   r_out_cnt <= r_out_cnt - CNT_W'(1);
                default: r_out_cnt <= r_out_cnt;
            endcase
            if (w_rtn_err) begin
                r_err <= 1'b1;
            end
        end
    end

`ifdef FPOP_SCHED_TIMEOUT_EN
    for (genvar g = 0; g < NTHR; g++) begin : g_to
        logic [TO_W-1:0] r_to_cnt;
        logic [TO_W-1:0] w_to_inc;
        logic            r_to;
        logic            w_clr;

        assign w_clr    = (w_ack && (r_tid == c_tid_w'(g))) ||
                          (w_rtn_ok && (cpx_tid == c_tid_w'(g)));
        assign w_to_inc = r_to_cnt + TO_W'(1);

        always_ff @(posedge rclk) begin
            if (rst || w_clr) begin
                r_to_cnt <= '0;
                r_to     <= 1'b0;
            end else if (r_busy[g] && (r_to_cnt != '1)) begin
                r_to_cnt <= w_to_inc;
                if (&w_to_inc) begin
                    r_to <= 1'b1;
                end
            end
        end

        assign thr_timeout[g] = r_to;
    end
`endif

    assign thr_req_gnt         = w_ack ? (NTHR'(1) << r_tid) : '0;
    assign ffu_lsu_fpop_rq_vld = (r_state == ST_REQ);
    assign ffu_lsu_fpop_tid    = r_tid;
    assign ffu_lsu_fpop_pld    = r_pld;
    assign thr_busy            = r_busy;
    assign thr_done            = r_done;
    assign out_cnt             = r_out_cnt;
    assign sched_err           = r_err;

endmodule
`default_nettype wire

// File: tb/tb_fpop_issue_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpop_issue_sched
// Brief    : Directed and randomized self-checking bench for fpop_issue_sched.
// Revision : 1.0  initial release
// ============================================================================
module tb_fpop_issue_sched;
    import fpop_sched_pkg::*;

    localparam int NTHR    = 4;
    localparam int PLW     = 80;
    localparam int MAX_OUT = 2;
`ifdef FPOP_SCHED_TIMEOUT_EN
    localparam int TO_W    = 4;
`else
    localparam int TO_W    = 10;
`endif
    localparam int CNT_W   = $clog2(MAX_OUT + 1);

    logic                rclk = 1'b0;
    logic                rst;
    logic [NTHR-1:0]     thr_req_vld;
    logic [NTHR*PLW-1:0] thr_req_pld;
    logic [NTHR-1:0]     thr_req_gnt;
    logic                ffu_lsu_fpop_rq_vld;
    logic [1:0]          ffu_lsu_fpop_tid;
    logic [PLW-1:0]      ffu_lsu_fpop_pld;
    logic                lsu_ffu_ack;
    logic                cpx_vld;
    logic                cpx_fpu_rtn;
    logic [1:0]          cpx_tid;
    logic [NTHR-1:0]     thr_busy;
    logic [NTHR-1:0]     thr_done;
    logic [CNT_W-1:0]    out_cnt;
    logic [NTHR-1:0]     thr_timeout;
    logic                sched_err;

    fpop_issue_sched #(
        .NTHR    (NTHR),
        .PLW     (PLW),
        .MAX_OUT (MAX_OUT),
        .TO_W    (TO_W)
    ) dut (
        .rclk                (rclk),
        .rst                 (rst),
        .thr_req_vld         (thr_req_vld),
        .thr_req_pld         (thr_req_pld),
        .thr_req_gnt         (thr_req_gnt),
        .ffu_lsu_fpop_rq_vld (ffu_lsu_fpop_rq_vld),
        .ffu_lsu_fpop_tid    (ffu_lsu_fpop_tid),
        .ffu_lsu_fpop_pld    (ffu_lsu_fpop_pld),
        .lsu_ffu_ack         (lsu_ffu_ack),
        .cpx_vld             (cpx_vld),
        .cpx_fpu_rtn         (cpx_fpu_rtn),
        .cpx_tid             (cpx_tid),
        .thr_busy            (thr_busy),
        .thr_done            (thr_done),
        .out_cnt             (out_cnt),
`ifdef FPOP_SCHED_TIMEOUT_EN
        .thr_timeout         (thr_timeout),
`endif
        .sched_err           (sched_err)
    );

`ifndef FPOP_SCHED_TIMEOUT_EN
    assign thr_timeout = '0;
`endif

    always #5 rclk = ~rclk;

    int n_pass  = 0;
    int n_total = 0;

    // reference model: pending presentation, busy set, pointer, sticky error, op age
    bit              m_req;
    int              m_tid;
    logic [PLW-1:0]  m_pld;
    int              m_rr;
    logic [NTHR-1:0] m_busy;
    logic [NTHR-1:0] m_done;
    bit              m_err;
    int              m_age [NTHR];
    int              last_gnt;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic int popc(input logic [NTHR-1:0] v);
        int n = 0;
        for (int i = 0; i < NTHR; i++) n += int'(v[i]);
        return n;
    endfunction

    function automatic logic [NTHR-1:0] exp_to();
        logic [NTHR-1:0] v = '0;
`ifdef FPOP_SCHED_TIMEOUT_EN
        for (int i = 0; i < NTHR; i++) v[i] = m_busy[i] && (m_age[i] >= (1 << TO_W) - 1);
`endif
        return v;
    endfunction

    task automatic model_edge();
        logic [NTHR-1:0] busy_pre;
        bit ack, rtn, ok, found;
        int t;
        busy_pre = m_busy;
        last_gnt = -1;
        if (rst) begin
            m_req = 0; m_tid = 0; m_pld = '0; m_rr = 0;
            m_busy = '0; m_done = '0; m_err = 0;
            for (int i = 0; i < NTHR; i++) m_age[i] = 0;
            return;
        end
        ack = m_req && lsu_ffu_ack;
        rtn = cpx_vld && cpx_fpu_rtn;
        ok  = rtn && busy_pre[cpx_tid];
        m_done = '0;
        if (ok) begin
            m_done[cpx_tid] = 1'b1;
            m_busy[cpx_tid] = 1'b0;
        end
        if (rtn && !ok) m_err = 1;
        for (int i = 0; i < NTHR; i++) if (busy_pre[i] && m_age[i] < 100000) m_age[i]++;
        if (ack) begin
            m_busy[m_tid] = 1'b1;
            m_age[m_tid]  = 0;
            last_gnt      = m_tid;
            m_req         = 0;
            m_rr          = (m_tid + 1) % NTHR;
        end else if (!m_req && popc(busy_pre) < MAX_OUT) begin
            found = 0;
            for (int k = 0; k < NTHR; k++) begin
                t = (m_rr + k) % NTHR;
                if (!found && thr_req_vld[t] && !busy_pre[t]) begin
                    found = 1;
                    m_req = 1;
                    m_tid = t;
                    m_pld = thr_req_pld[t*PLW +: PLW];
                end
            end
        end
    endtask

    task automatic check_regs();
        chk("rq_vld", ffu_lsu_fpop_rq_vld, m_req);
        if (m_req) begin
            chk("tid", ffu_lsu_fpop_tid, m_tid);
            chk("pld", ffu_lsu_fpop_pld, m_pld);
        end
        chk("busy", thr_busy, m_busy);
        chk("done", thr_done, m_done);
        chk("out_cnt", out_cnt, popc(m_busy));
        chk("sched_err", sched_err, m_err);
        chk("timeout", thr_timeout, exp_to());
    endtask

    // one clock: grant check mid-cycle, model advance at the edge, outputs on negedge
    task automatic step();
        logic [NTHR-1:0] g;
        #1;
        g = '0;
        if (m_req && lsu_ffu_ack) g[m_tid] = 1'b1;
        chk("gnt", thr_req_gnt, g);
        @(posedge rclk);
        model_edge();
        @(negedge rclk);
        check_regs();
    endtask

    task automatic drive(input logic [NTHR-1:0] v, input logic a, input logic rv, input int rt);
        thr_req_vld = v;
        lsu_ffu_ack = a;
        cpx_vld     = rv;
        cpx_fpu_rtn = rv;
        cpx_tid     = 2'(rt);
    endtask

    task automatic do_reset();
        drive('0, 1'b0, 1'b0, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [PLW-1:0] bp_pld;
        int ngnt;
        logic [NTHR-1:0] req;

        m_req = 0; m_tid = 0; m_pld = '0; m_rr = 0; m_busy = '0; m_done = '0; m_err = 0;
        for (int i = 0; i < NTHR; i++) m_age[i] = 0;
        last_gnt = -1;
        thr_req_pld = '0;
        drive('0, 1'b0, 1'b0, 0);
        rst = 1'b1;
        repeat (2) begin
            @(posedge rclk);
            model_edge();
        end
        @(negedge rclk);
        chk("reset_rq_vld", ffu_lsu_fpop_rq_vld, 0);
        chk("reset_tid", ffu_lsu_fpop_tid, 0);
        chk("reset_pld", ffu_lsu_fpop_pld, 0);
        chk("reset_busy", thr_busy, 0);
        chk("reset_done", thr_done, 0);
        chk("reset_out_cnt", out_cnt, 0);
        chk("reset_err", sched_err, 0);
        chk("reset_gnt", thr_req_gnt, 0);
        chk("reset_timeout", thr_timeout, 0);
        rst = 1'b0;

        // single op on thread 2
        thr_req_pld[2*PLW +: PLW] = 80'h1234_5678_9ABC_DEF0_1357;
        drive(4'b0100, 1'b0, 1'b0, 0);
        step();
        chk("single_rq_vld", ffu_lsu_fpop_rq_vld, 1);
        chk("single_tid", ffu_lsu_fpop_tid, 2);
        chk("single_pld", ffu_lsu_fpop_pld, 80'h1234_5678_9ABC_DEF0_1357);
        lsu_ffu_ack = 1'b1;
        #1 chk("single_gnt", thr_req_gnt, 4'b0100);
        step();
        chk("single_busy", thr_busy, 4'b0100);
        chk("single_cnt", out_cnt, 1);
        drive('0, 1'b0, 1'b1, 2);
        step();
        chk("single_done", thr_done, 4'b0100);
        chk("single_cnt0", out_cnt, 0);
        drive('0, 1'b0, 1'b0, 0);
        step();

        // backpressure: ack withheld five cycles
        bp_pld = 80'hCAFE_0000_BEEF_1111_2222;
        thr_req_pld[1*PLW +: PLW] = bp_pld;
        drive(4'b0010, 1'b0, 1'b0, 0);
        step();
        ngnt = 0;
        for (int i = 0; i < 6; i++) begin
            lsu_ffu_ack = (i == 5);
            #1 if (|thr_req_gnt) ngnt++;
            chk("bp_rq_vld", ffu_lsu_fpop_rq_vld, 1);
            chk("bp_tid", ffu_lsu_fpop_tid, 1);
            chk("bp_pld", ffu_lsu_fpop_pld, bp_pld);
            step();
        end
        chk("bp_one_grant", ngnt, 1);
        drive('0, 1'b0, 1'b1, 1);
        step();

        // stray return, then ack(t0) racing a valid return(t1)
        drive('0, 1'b0, 1'b1, 1);
        step();
        chk("err_set", sched_err, 1);
        chk("err_cnt", out_cnt, 0);
        drive(4'b0010, 1'b1, 1'b0, 0); step();
        drive(4'b0010, 1'b1, 1'b0, 0); step();
        drive(4'b0001, 1'b0, 1'b0, 0); step();
        drive(4'b0001, 1'b1, 1'b1, 1); step();
        chk("race_cnt", out_cnt, 1);
        chk("race_busy", thr_busy, 4'b0001);
        chk("err_sticky", sched_err, 1);
        do_reset();

        // cap of two in flight: thread 3 waits for a return
        drive(4'b1011, 1'b1, 1'b0, 0); step();
        drive(4'b1010, 1'b1, 1'b0, 0); step();
        step();
        drive(4'b1000, 1'b1, 1'b0, 0); step();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("cap_hold", ffu_lsu_fpop_rq_vld, 0);
        end
        drive(4'b1000, 1'b0, 1'b1, 0); step();
        chk("cap_after_rtn", ffu_lsu_fpop_rq_vld, 0);
        drive(4'b1000, 1'b0, 1'b0, 0); step();
        chk("cap_issue", ffu_lsu_fpop_rq_vld, 1);
        chk("cap_tid", ffu_lsu_fpop_tid, 3);
        do_reset();

        // reset during REQ, then a return for the pre-reset op
        drive(4'b0100, 1'b1, 1'b0, 0); step();
        drive(4'b1000, 1'b1, 1'b0, 0); step();
        drive(4'b1000, 1'b0, 1'b0, 0); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_rq_vld", ffu_lsu_fpop_rq_vld, 0);
        chk("rst_busy", thr_busy, 0);
        chk("rst_cnt", out_cnt, 0);
        drive('0, 1'b0, 1'b1, 2); step();
        chk("rst_stale_err", sched_err, 1);
        do_reset();

`ifdef FPOP_SCHED_TIMEOUT_EN
        drive(4'b0001, 1'b1, 1'b0, 0); step();
        step();
        drive('0, 1'b0, 1'b0, 0);
        for (int k = 1; k <= 15; k++) begin
            step();
            if (k == 14) chk("to_before", thr_timeout, 4'b0000);
            if (k == 15) chk("to_rise", thr_timeout, 4'b0001);
        end
        drive('0, 1'b0, 1'b1, 0); step();
        chk("to_clear", thr_timeout, 4'b0000);
        do_reset();
`endif

        // randomized traffic
        req = '0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            rst = ($urandom_range(0, 299) == 0);
            for (int t = 0; t < NTHR; t++) begin
                if (last_gnt == t) begin
                    req[t] = 1'b0;
                end else if (!req[t] && $urandom_range(0, 3) == 0) begin
                    req[t] = 1'b1;
                    thr_req_pld[t*PLW +: PLW] = PLW'({$urandom(), $urandom(), $urandom()});
                end
            end
            thr_req_vld = req;
            lsu_ffu_ack = 1'($urandom_range(0, 1));
            cpx_vld     = ($urandom_range(0, 2) == 0);
            cpx_fpu_rtn = cpx_vld && ($urandom_range(0, 9) != 0);
            cpx_tid     = 2'($urandom_range(0, NTHR - 1));
            if (m_busy != '0 && $urandom_range(0, 19) != 0) begin
                while (!m_busy[cpx_tid]) cpx_tid = 2'($urandom_range(0, NTHR - 1));
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fpop_issue_sched.md
# fpop_issue_sched

Per-core scheduler that shares the single FFU-to-LSU floating-point-op request path among the four SPARC hardware threads. It holds each thread's pending fpop, picks one round-robin, presents it to the LSU with a valid/ack handshake, and tracks in-flight ops until the matching FPU return arrives on the CPX. It sits inside the FFU, between the per-thread fpop staging logic and the `ffu_lsu_fpop_rq_vld` / `lsu_ffu_ack` interface.

## Interface
Parameters:
- `NTHR`, 4: hardware threads; thread ID width is fixed at 2.
- `PLW`, 80: fpop payload width (opcode, rd, fcc, operand tags).
- `MAX_OUT`, 2: maximum fpops in flight at the FPU, range 1..NTHR.
- `TO_W`, 10: width of the per-thread watchdog counter (with `FPOP_SCHED_TIMEOUT_EN` only).

Ports:
- Clock/reset: one clock; reset is synchronous and active-high.
- `rclk` in 1: core clock.
- `rst` in 1: synchronous, active-high reset.
- `thr_req_vld` in NTHR: per-thread request; a level held until granted.
- `thr_req_pld` in NTHR*PLW: per-thread payload; thread t occupies bits [t*PLW +: PLW].
- `thr_req_gnt` out NTHR: one-hot; `ffu_lsu_fpop_rq_vld & lsu_ffu_ack` decoded to the issuing thread.
- `ffu_lsu_fpop_rq_vld` out 1: request to the LSU.
- `ffu_lsu_fpop_tid` out 2: thread of the presented request.
- `ffu_lsu_fpop_pld` out PLW: payload of the presented request.
- `lsu_ffu_ack` in 1: LSU accepts the presented request this cycle.
- `cpx_vld` in 1: CPX packet valid.
- `cpx_fpu_rtn` in 1: decoded `cpx_req` equals FPU return.
- `cpx_tid` in 2: thread of the CPX return.
- `thr_busy` out NTHR: thread has an fpop in flight.
- `thr_done` out NTHR: one-cycle completion pulse.
- `out_cnt` out $clog2(MAX_OUT+1): number of fpops in flight.
- `sched_err` out 1: sticky flag for an unexpected return.
- `thr_timeout` out NTHR: present only with `FPOP_SCHED_TIMEOUT_EN`.

## Operation
- FSM states are IDLE and REQ.
- IDLE:
  - Eligible set = `thr_req_vld & ~thr_busy`.
  - If the set is non-empty and `out_cnt < MAX_OUT`: the arbiter picks a winner starting at `rr_ptr`, latches its tid and payload, and moves to REQ.
- REQ:
  - `ffu_lsu_fpop_rq_vld`=1; tid and payload stay stable.
  - On `lsu_ffu_ack`:
    - `thr_req_gnt[tid]`=1 for that cycle.
    - Next edge: `thr_busy[tid]` set, `out_cnt`+1, `rr_ptr` = tid+1 mod NTHR, state goes to IDLE.
  - No retraction: REQ is held regardless of `thr_req_vld` until ack arrives.
- Return handling, when `cpx_vld & cpx_fpu_rtn`:
  - If `thr_busy[cpx_tid]`=1: next edge clears busy, decrements `out_cnt`, and pulses `thr_done[cpx_tid]` for 1 cycle.
  - If `thr_busy[cpx_tid]`=0: the return is ignored and `sched_err` is set. It stays set until `rst`.
- Simultaneous ack (thread a) and valid return (thread b≠a) in the same cycle: `out_cnt` is unchanged; both busy bits update.
- Ack and return for the same tid in the same cycle: busy is not yet set, so the return is an error. `sched_err` is set and busy is then set by the ack.
- `out_cnt` never exceeds MAX_OUT and never underflows; the IDLE gate and the busy check guarantee this.
- Reset mid-operation:
  - All state clears, and the request drops the next cycle.
  - Returns for pre-reset ops arriving afterwards set `sched_err`.

## Timing
- Reset values: state=IDLE, `rr_ptr`=0, `ffu_lsu_fpop_rq_vld`=0, `ffu_lsu_fpop_tid`=0, `ffu_lsu_fpop_pld`=0, `thr_busy`=0, `thr_done`=0, `out_cnt`=0, `sched_err`=0, `thr_timeout`=0. `thr_req_gnt`=0 follows from rq_vld=0.
- Request latency: `thr_req_vld` rising at cycle N (eligible, FSM in IDLE) gives `ffu_lsu_fpop_rq_vld` at N+1.
- Throughput: ack at cycle M gives the earliest next request at M+2. There is one IDLE bubble, so the peak rate is 1 issue per 2 cycles.
- Completion latency: a return at cycle R gives `thr_done` at R+1 and `thr_busy` low at R+1. The thread is eligible again in IDLE at R+1.
- All outputs are registered except `thr_req_gnt`.

## Configuration
- Macro: `FPOP_SCHED_TIMEOUT_EN`.
- Defined:
  - Each busy thread runs a `TO_W`-bit counter that increments every cycle and saturates at all-ones.
  - At saturation, `thr_timeout[t]` is set. It clears on that thread's return or on `rst`.
  - The counter clears when the op is issued.
- Undefined: no counters, and the `thr_timeout` port is absent. All other behaviour is identical.

## Structure
- Shared package `fpop_sched_pkg` holds:
  - FSM state encoding (IDLE=0, REQ=1).
  - The CPX FPU-return request type constant used to build `cpx_fpu_rtn`.
  - The tid width constant.
- Sub-module `fpop_rr_arb`: an NTHR-way round-robin priority picker. It is purely combinational (eligible vector, `rr_ptr` in; one-hot grant and encoded tid out).

## Test plan
- Single op: after reset, thread 2 requests; ack one cycle after rq_vld → `rq_vld` at N+1 with tid=2; `thr_req_gnt`=0100 on the ack cycle; `thr_busy`=0100, `out_cnt`=1. Return tid=2 → `thr_done`=0100 one cycle later, `out_cnt`=0.
- Fairness: all 4 threads hold requests, MAX_OUT=4, ack always high, no returns → issue order 0,1,2,3 at 2-cycle spacing, then nothing (all busy).
- Cap: MAX_OUT=2, threads 0,1,3 request → 0 and 1 issue; 3 waits until a return for 0 arrives, then issues 2 cycles after that return.
- Backpressure: ack withheld 5 cycles → rq_vld, tid and payload stable for all 6 cycles; exactly one grant pulse.
- Errors: return tid=1 with nothing busy → `sched_err`=1, `out_cnt` stays 0. Simultaneous ack(t0) and return(t1, busy) → `out_cnt` unchanged, busy=0001.
- Reset mid-REQ plus timeout (`FPOP_SCHED_TIMEOUT_EN`, TO_W=4): assert `rst` during REQ → rq_vld=0 next cycle, all outputs at reset values. In a separate case, an op is left unreturned → `thr_timeout` for that thread rises 15 cycles after issue.
